// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// common baud divisors at 50 MHz and frame-length constants.
package uart_pkg;

    // Transmit FSM states; IDLE must stay at zero so a reset register reads IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // clk cycles per bit for a 50 MHz system clock.
    localparam int CLKS_921600 = 54;
    localparam int CLKS_115200 = 434;

    // Frame lengths in bit periods: start + 8 data + stop, plus optional parity.
    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS_PLAIN  = 10;
    localparam int FRAME_BITS_PARITY = 11;

    // Number of bit periods in one frame for a given parity setting.
    function automatic int frame_bits(input int parity_en);
        return (parity_en != 0) ? FRAME_BITS_PARITY : FRAME_BITS_PLAIN;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Single-channel UART serialiser. A one-cycle load pulse in IDLE captures a
// byte; the core then drives start, 8 data bits LSB-first, optional parity
// and stop, each held CLKS_PER_BIT cycles. txd is registered so the pin never
// sees decode glitches; busy and state are decodes of the state register.
import uart_pkg::*;

module uart_tx_core #(
    parameter int CLKS_PER_BIT = CLKS_921600,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output tx_state_t  state
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          bit_done;

    assign bit_done = (timer_q == LAST_TICK);

    // State, timer, shift register and line register; reset forces the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    // Next state and next line level; the timer restarts at every bit boundary.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        txd_d   = txd_q;
        if (state_q != ST_IDLE && !bit_done) begin
            timer_d = timer_q + TW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (load) begin
                    state_d = ST_START;
                    shreg_d = data;
                    par_d   = (^data) ^ (PARITY_ODD != 0);
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    txd_d   = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign txd   = txd_q;
    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end sharing one UART transmitter among N_REQ producers.
// Handshake: a byte moves on any cycle where req_valid[i] & req_ready[i] are
// both high; req_ready is combinational, one-hot, and only raised while the
// transmitter is idle. Producers may drop valid at any time before ready.
import uart_pkg::*;

module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int CLKS_PER_BIT = CLKS_921600,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               txd,
    output logic               busy,
    output logic [GW-1:0]      grant_id
);

    logic [GW-1:0] last_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] winner;
    logic [GW-1:0] cand;
    logic          found;
    logic          load;
    logic [7:0]    load_data;
    tx_state_t     core_state;

    // Pick the first valid requester searching upward from the one after the last grant.
    always_comb begin
        winner    = '0;
        cand      = '0;
        found     = 1'b0;
        req_ready = '0;
        load_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = GW'((int'(last_q) + 1 + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        load = !rst && (core_state == ST_IDLE) && found;
        if (load) begin
            req_ready[winner] = 1'b1;
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == GW'(k)) begin
                load_data = req_data[8*k +: 8];
            end
        end
    end

    // Round-robin pointer and visible grant; reset gives requester 0 top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= GW'(N_REQ - 1);
            grant_q <= '0;
        end else if (load) begin
            last_q  <= winner;
            grant_q <= winner;
        end
    end

    assign grant_id = grant_q;

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_EN    (PARITY_EN),
        .PARITY_ODD   (PARITY_ODD)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (load_data),
        .txd   (txd),
        .busy  (busy),
        .state (core_state)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Three instances share clk/rst:
//   unit 0: N_REQ=3, no parity; unit 1: N_REQ=2, even parity; unit 2: N_REQ=1, odd parity.
// A frame-level model checks every cycle; directed tests pin it with literals.
module tb_uart_tx_arbiter;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  valid [3];
    logic [23:0] data  [3];
    logic [2:0]  ready [3];
    logic        txd   [3];
    logic        busy  [3];
    logic [1:0]  gid   [3];

    logic [2:0] rdy0;
    logic [1:0] rdy1;
    logic       rdy2;
    logic       tx0, tx1, tx2, bz0, bz1, bz2;
    logic [1:0] g0;
    logic       g1, g2;

    uart_tx_arbiter #(.N_REQ(3), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_data(data[0]),
        .req_ready(rdy0), .txd(tx0), .busy(bz0), .grant_id(g0));
    uart_tx_arbiter #(.N_REQ(2), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .req_valid(valid[1][1:0]), .req_data(data[1][15:0]),
        .req_ready(rdy1), .txd(tx1), .busy(bz1), .grant_id(g1));
    uart_tx_arbiter #(.N_REQ(1), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .req_valid(valid[2][0:0]), .req_data(data[2][7:0]),
        .req_ready(rdy2), .txd(tx2), .busy(bz2), .grant_id(g2));

    always_comb begin
        ready[0] = rdy0;  ready[1] = {1'b0, rdy1};  ready[2] = {2'b00, rdy2};
        txd[0]   = tx0;   txd[1]   = tx1;           txd[2]   = tx2;
        busy[0]  = bz0;   busy[1]  = bz1;           busy[2]  = bz2;
        gid[0]   = g0;    gid[1]   = {1'b0, g1};    gid[2]   = {1'b0, g2};
    end

    int n_req   [3] = '{3, 2, 1};
    int par_en  [3] = '{0, 1, 1};
    int par_odd [3] = '{0, 0, 1};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- frame-level model + scoreboard ----------------
    int   m_last [3];
    int   m_grant[3];
    int   m_pos  [3];
    int   m_len  [3];
    bit   m_act  [3];
    bit   m_bits [3][11];
    logic [9:0] exp_q[$];
    bit   sb_on = 1'b0;

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            int         win;
            int         idx;
            int         ai;
            logic [2:0] er;
            logic       et;
            logic [9:0] e;
            if (rst) begin
                m_last[u] = n_req[u] - 1; m_grant[u] = 0; m_act[u] = 1'b0; m_pos[u] = 0;
            end
            win = -1;
            if (!rst && !m_act[u]) begin
                for (int j = 0; j < n_req[u]; j++) begin
                    idx = (m_last[u] + 1 + j) % n_req[u];
                    if (win < 0 && valid[u][idx]) win = idx;
                end
            end
            er = (win >= 0) ? 3'(1 << win) : 3'b000;
            et = m_act[u] ? m_bits[u][m_pos[u] / CPB] : 1'b1;
            chk($sformatf("mdl_txd_u%0d", u),   txd[u],   et);
            chk($sformatf("mdl_busy_u%0d", u),  busy[u],  m_act[u]);
            chk($sformatf("mdl_ready_u%0d", u), ready[u], er);
            chk($sformatf("mdl_gid_u%0d", u),   gid[u],   m_grant[u]);
            if (u == 0 && sb_on && !rst && ready[0] != 3'b000) begin
                if (exp_q.size() == 0) chk("sb_extra_grant", ready[0], 0);
                else begin
                    e  = exp_q.pop_front();
                    ai = ready[0][2] ? 2 : (ready[0][1] ? 1 : 0);
                    chk("sb_grant", {2'(ai), data[0][8*ai +: 8]}, e);
                end
            end
            if (!rst) begin
                if (m_act[u]) begin
                    m_pos[u]++;
                    if (m_pos[u] == m_len[u] * CPB) m_act[u] = 1'b0;
                end else if (win >= 0) begin
                    m_bits[u][0] = 1'b0;
                    for (int b = 0; b < 8; b++) m_bits[u][1+b] = data[u][8*win + b];
                    if (par_en[u] != 0) begin
                        m_bits[u][9]  = (^data[u][8*win +: 8]) ^ (par_odd[u] != 0);
                        m_bits[u][10] = 1'b1;
                        m_len[u] = 11;
                    end else begin
                        m_bits[u][9] = 1'b1;
                        m_len[u] = 10;
                    end
                    m_act[u] = 1'b1; m_pos[u] = 0; m_grant[u] = win; m_last[u] = win;
                end
            end
        end
    end

    // ---------------- drivers and trace ----------------
    logic [7:0] src   [9][2];
    int         src_n [9];
    int         src_i [9];
    bit         tr_txd  [3][512];
    bit         tr_busy [3][512];
    logic [2:0] tr_rdy  [3][512];
    logic [1:0] tr_gid  [3][512];
    int         tr_n = 0;

    task automatic do_reset();
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            valid[u] = 3'b000; data[u] = 24'h0;
        end
        for (int i = 0; i < 9; i++) begin src_n[i] = 0; src_i[i] = 0; end
        @(posedge clk); #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_txd_u%0d", u),   txd[u],   1);
            chk($sformatf("rst_busy_u%0d", u),  busy[u],  0);
            chk($sformatf("rst_ready_u%0d", u), ready[u], 0);
            chk($sformatf("rst_gid_u%0d", u),   gid[u],   0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tr_n = 0;
    endtask

    task automatic load_src(input int u, input int k, input logic [7:0] b0,
                            input logic [7:0] b1, input int n);
        src[u*3+k][0] = b0; src[u*3+k][1] = b1;
        src_n[u*3+k] = n; src_i[u*3+k] = 0;
        data[u][8*k +: 8] = b0;
        valid[u][k] = (n > 0);
    endtask

    // Runs n cycles: trace at negedge, producers advance after each handshake.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            logic [2:0] hs [3];
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                if (tr_n < 512) begin
                    tr_txd[u][tr_n] = txd[u]; tr_busy[u][tr_n] = busy[u];
                    tr_rdy[u][tr_n] = ready[u]; tr_gid[u][tr_n] = gid[u];
                end
                hs[u] = ready[u] & valid[u];
            end
            if (tr_n < 511) tr_n++;
            @(posedge clk); #1;
            for (int u = 0; u < 3; u++) begin
                for (int k = 0; k < 3; k++) begin
                    if (hs[u][k]) begin
                        src_i[u*3+k]++;
                        if (src_i[u*3+k] < src_n[u*3+k]) data[u][8*k +: 8] = src[u*3+k][src_i[u*3+k]];
                        else valid[u][k] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Compares each bit slot of a traced frame (slot 0 = start bit) and the busy window.
    task automatic check_frame(input int u, input int start, input int nslots,
                               input logic [10:0] expbits, input string name);
        logic [3:0] act4;
        int cnt;
        for (int s = 0; s < nslots; s++) begin
            for (int c = 0; c < 4; c++) act4[c] = tr_txd[u][start + 4*s + c];
            chk($sformatf("%s_slot%0d", name, s), act4, {4{expbits[s]}});
        end
        cnt = 0;
        for (int i = start; i < start + 4*nslots; i++) if (tr_busy[u][i]) cnt++;
        chk($sformatf("%s_busy_len", name), cnt, 4*nslots);
        chk($sformatf("%s_busy_after", name), tr_busy[u][start + 4*nslots], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] order [5];
        int cnt0, cnt1, cnt2;

        // A: single byte 0xA5 on requester 0
        do_reset();
        load_src(0, 0, 8'hA5, 8'h00, 1);
        run(45);
        chk("a_ready", tr_rdy[0][0], 3'b001);
        check_frame(0, 1, 10, 11'b01101001010, "a_frame");
        chk("a_gid", tr_gid[0][1], 0);

        // B: two simultaneous requests
        do_reset();
        load_src(0, 0, 8'h11, 8'h00, 1);
        load_src(0, 1, 8'h22, 8'h00, 1);
        run(90);
        chk("b_ready0", tr_rdy[0][0], 3'b001);
        chk("b_gap_txd", tr_txd[0][41], 1);
        chk("b_ready1", tr_rdy[0][41], 3'b010);
        check_frame(0, 1, 10, 11'b01000100010, "b_frame0");
        check_frame(0, 42, 10, 11'b01001000100, "b_frame1");
        chk("b_gid0", tr_gid[0][1], 0);
        chk("b_gid1", tr_gid[0][42], 1);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 90; i++) begin
            if (tr_rdy[0][i][0]) cnt0++;
            if (tr_rdy[0][i][1]) cnt1++;
        end
        chk("b_pulses0", cnt0, 1);
        chk("b_pulses1", cnt1, 1);

        // C: three requesters continuously valid
        do_reset();
        load_src(0, 0, 8'h31, 8'h32, 2);
        load_src(0, 1, 8'h41, 8'h42, 2);
        load_src(0, 2, 8'h51, 8'h00, 1);
        exp_q.push_back({2'd0, 8'h31}); exp_q.push_back({2'd1, 8'h41});
        exp_q.push_back({2'd2, 8'h51}); exp_q.push_back({2'd0, 8'h32});
        exp_q.push_back({2'd1, 8'h42});
        sb_on = 1'b1;
        run(210);
        sb_on = 1'b0;
        chk("c_sb_drain", exp_q.size(), 0);
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001; order[4] = 3'b010;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("c_order%0d", k), tr_rdy[0][41*k], order[k]);
            if (k > 0) begin
                chk($sformatf("c_stop_end%0d", k), tr_busy[0][41*k - 1], 1);
                chk($sformatf("c_gap%0d", k), tr_txd[0][41*k], 1);
            end
        end

        // D: parity, even on unit 1 and odd on unit 2, byte 0x07
        do_reset();
        load_src(1, 0, 8'h07, 8'h00, 1);
        load_src(2, 0, 8'h07, 8'h00, 1);
        run(50);
        chk("d_ready_even", tr_rdy[1][0], 3'b001);
        chk("d_ready_odd", tr_rdy[2][0], 3'b001);
        check_frame(1, 1, 11, 11'b11000001110, "d_even");
        check_frame(2, 1, 11, 11'b10000001110, "d_odd");

        // E: asynchronous reset during data bit 3, then req1 served first
        do_reset();
        load_src(0, 0, 8'hF0, 8'h00, 1);
        run(19);
        #1;
        chk("e_pre_txd", txd[0], 0);
        chk("e_pre_busy", busy[0], 1);
        rst = 1'b1;
        #1;
        chk("e_async_txd", txd[0], 1);
        chk("e_async_busy", busy[0], 0);
        chk("e_async_ready", ready[0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tr_n = 0;
        load_src(0, 1, 8'h3C, 8'h00, 1);
        run(45);
        chk("e_ready", tr_rdy[0][0], 3'b010);
        check_frame(0, 1, 10, 11'b01001111000, "e_frame");
        chk("e_gid", tr_gid[0][1], 1);

        // F: one-cycle valid pulse from req1 while busy is ignored
        do_reset();
        load_src(0, 0, 8'h5A, 8'h00, 1);
        run(10);
        data[0][15:8] = 8'h99;
        valid[0][1] = 1'b1;
        run(1);
        valid[0][1] = 1'b0;
        run(60);
        chk("f_ready", tr_rdy[0][0], 3'b001);
        check_frame(0, 1, 10, 11'b01010110100, "f_frame");
        cnt0 = 0; cnt1 = 0; cnt2 = 0;
        for (int i = 1; i < 71; i++) if (tr_rdy[0][i] != 3'b000) cnt0++;
        for (int i = 41; i < 71; i++) begin
            if (tr_txd[0][i]) cnt1++;
            if (tr_busy[0][i]) cnt2++;
        end
        chk("f_no_grant", cnt0, 0);
        chk("f_idle_high", cnt1, 30);
        chk("f_idle_busy", cnt2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
